// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: EX-stage decoder and WB-stage control register
// for the two-stage RV32 core. It decodes R/I-type ALU ops, lui and csrrw
// to the GPIO CSRs, flags anything else as illegal, and registers the WB
// controls with a one-cycle EX->WB latency.
// Optional macro CU_MEXT_EN: enables mul/mulh/mulhu decode and the
// multi-cycle multiply stall FSM. When it is undefined those encodings are
// illegal and stall_fetch is tied low.
module pipelined_control_unit #(
  parameter int          NUM_GPIO_OUT  = 2,
  parameter logic [11:0] GPIO_OUT_BASE = 12'hF02,
  parameter logic [11:0] GPIO_IN_ADDR  = 12'hF00,
  parameter int          MUL_CYCLES    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr_ex,
  input  logic                    instr_valid,
  output logic [3:0]              aluop_ex,
  output logic                    alusrc_ex,
  output logic                    stall_fetch,
  output logic                    illegal_ex,
  output logic [1:0]              regsel_wb,
  output logic                    regwrite_wb,
  output logic [4:0]              rd_wb,
  output logic [NUM_GPIO_OUT-1:0] gpio_we_wb
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [1:0] SEL_GPIO = 2'b00;
  localparam logic [1:0] SEL_IMMU = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [11:0] csr_addr;
  logic        unused_rs1;

  assign opcode     = instr_ex[6:0];
  assign rd         = instr_ex[11:7];
  assign funct3     = instr_ex[14:12];
  assign funct7     = instr_ex[31:25];
  assign csr_addr   = instr_ex[31:20];
  // rs1 is consumed by the datapath, never by the control decode
  assign unused_rs1 = ^instr_ex[19:15];

  // One comparator per GPIO output CSR
  logic [NUM_GPIO_OUT-1:0] gpio_hit;
  generate
    for (genvar gi = 0; gi < NUM_GPIO_OUT; gi++) begin : g_gpio_hit
      localparam logic [11:0] ADDR = GPIO_OUT_BASE + 12'(gi);
      assign gpio_hit[gi] = (csr_addr == ADDR);
    end
  endgenerate

  logic [1:0]              regsel_dec;
  logic                    regwrite_dec;
  logic [NUM_GPIO_OUT-1:0] gpio_dec;
  logic                    legal_dec;
`ifdef CU_MEXT_EN
  logic                    is_mul;
`endif

  // Instruction decode; legal_dec is set only for fully recognised encodings
  always_comb begin
    aluop_ex     = 4'b0011;
    alusrc_ex    = 1'b0;
    regsel_dec   = SEL_ALU;
    regwrite_dec = 1'b0;
    gpio_dec     = '0;
    legal_dec    = 1'b0;
`ifdef CU_MEXT_EN
    is_mul       = 1'b0;
`endif
    case (opcode)
      OP_R: begin
        regwrite_dec = 1'b1;
        case (funct7)
          7'b0000000: begin
            legal_dec = 1'b1;
            case (funct3)
              3'b000:  aluop_ex = 4'b0011;
              3'b001:  aluop_ex = 4'b1000;
              3'b010:  aluop_ex = 4'b1100;
              3'b011:  aluop_ex = 4'b1101;
              3'b100:  aluop_ex = 4'b0010;
              3'b101:  aluop_ex = 4'b1001;
              3'b110:  aluop_ex = 4'b0001;
              default: aluop_ex = 4'b0000;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              aluop_ex  = 4'b0100;
              legal_dec = 1'b1;
            end else if (funct3 == 3'b101) begin
              aluop_ex  = 4'b1010;
              legal_dec = 1'b1;
            end
          end
`ifdef CU_MEXT_EN
          7'b0000001: begin
            // funct3 000/001/011 select mul, mulh and mulhu
            if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b011) begin
              legal_dec = 1'b1;
              is_mul    = 1'b1;
              case (funct3)
                3'b000:  aluop_ex = 4'b0101;
                3'b001:  aluop_ex = 4'b0110;
                default: aluop_ex = 4'b0111;
              endcase
            end
          end
`endif
          default: ;
        endcase
      end
      OP_I: begin
        alusrc_ex    = 1'b1;
        regwrite_dec = 1'b1;
        case (funct3)
          3'b000: begin aluop_ex = 4'b0011; legal_dec = 1'b1; end
          3'b010: begin aluop_ex = 4'b1100; legal_dec = 1'b1; end
          3'b011: begin aluop_ex = 4'b1101; legal_dec = 1'b1; end
          3'b100: begin aluop_ex = 4'b0010; legal_dec = 1'b1; end
          3'b110: begin aluop_ex = 4'b0001; legal_dec = 1'b1; end
          3'b111: begin aluop_ex = 4'b0000; legal_dec = 1'b1; end
          3'b001: begin
            aluop_ex  = 4'b1000;
            legal_dec = (funct7 == 7'b0000000);
          end
          default: begin
            if (funct7 == 7'b0000000) begin
              aluop_ex  = 4'b1001;
              legal_dec = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              aluop_ex  = 4'b1010;
              legal_dec = 1'b1;
            end
          end
        endcase
      end
      OP_LUI: begin
        alusrc_ex    = 1'b1;
        regsel_dec   = SEL_IMMU;
        regwrite_dec = 1'b1;
        legal_dec    = 1'b1;
      end
      OP_SYS: begin
        if (funct3 == 3'b001) begin
          if (|gpio_hit) begin
            gpio_dec  = gpio_hit;
            legal_dec = 1'b1;
          end else if (csr_addr == GPIO_IN_ADDR) begin
            regsel_dec   = SEL_GPIO;
            regwrite_dec = 1'b1;
            legal_dec    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign illegal_ex = instr_valid & ~legal_dec;

`ifdef CU_MEXT_EN
  localparam logic STATE_IDLE     = 1'b0;
  localparam logic STATE_MUL_BUSY = 1'b1;
  localparam int   CNT_W          = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  logic             state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stall_next;
  logic             mul_ex;

  assign mul_ex = instr_valid & is_mul;

  // Multiply sequencer: hold fetch until the multiply has had MUL_CYCLES
  // EX cycles; losing instr_valid mid-sequence abandons it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_next = 1'b0;
    if (state_reg == STATE_IDLE) begin
      if (mul_ex && (MUL_CYCLES > 1)) begin
        stall_next = 1'b1;
        state_next = STATE_MUL_BUSY;
        cnt_next   = CNT_W'(1);
      end
    end else begin
      if (!instr_valid) begin
        state_next = STATE_IDLE;
        cnt_next   = '0;
      end else if (cnt_reg < CNT_LAST) begin
        stall_next = 1'b1;
        cnt_next   = cnt_reg + CNT_W'(1);
      end else begin
        state_next = STATE_IDLE;
        cnt_next   = '0;
      end
    end
  end

  // FSM state and cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= STATE_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Reset releases the stall immediately, not at the next edge
  assign stall_fetch = stall_next & ~rst;
`else
  assign stall_fetch = 1'b0;
`endif

  logic                    take_ex;
  logic [1:0]              regsel_next;
  logic                    regwrite_next;
  logic [4:0]              rd_next;
  logic [NUM_GPIO_OUT-1:0] gpio_we_next;

  // Bubbles, illegal ops and stalled cycles all reach WB as no-ops
  assign take_ex       = instr_valid & legal_dec & ~stall_fetch;
  assign regsel_next   = take_ex ? regsel_dec : SEL_ALU;
  assign rd_next       = take_ex ? rd : 5'd0;
  assign regwrite_next = take_ex & regwrite_dec & (rd != 5'd0);
  assign gpio_we_next  = take_ex ? gpio_dec : '0;

  // EX->WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regsel_wb   <= SEL_ALU;
      regwrite_wb <= 1'b0;
      rd_wb       <= 5'd0;
      gpio_we_wb  <= '0;
    end else begin
      regsel_wb   <= regsel_next;
      regwrite_wb <= regwrite_next;
      rd_wb       <= rd_next;
      gpio_we_wb  <= gpio_we_next;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed testbench for pipelined_control_unit (default parameters).
// Expected values are hand-decoded from the instruction encodings.
module tb_pipelined_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr_ex;
  logic        instr_valid;
  logic [3:0]  aluop_ex;
  logic        alusrc_ex;
  logic        stall_fetch;
  logic        illegal_ex;
  logic [1:0]  regsel_wb;
  logic        regwrite_wb;
  logic [4:0]  rd_wb;
  logic [1:0]  gpio_we_wb;

  int errors = 0;
  int checks = 0;

  pipelined_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_ex    (instr_ex),
    .instr_valid (instr_valid),
    .aluop_ex    (aluop_ex),
    .alusrc_ex   (alusrc_ex),
    .stall_fetch (stall_fetch),
    .illegal_ex  (illegal_ex),
    .regsel_wb   (regsel_wb),
    .regwrite_wb (regwrite_wb),
    .rd_wb       (rd_wb),
    .gpio_we_wb  (gpio_we_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an instruction at the falling edge; comb outputs settle 1ns later
  task automatic drive(input logic [31:0] ins, input logic v);
    @(negedge clk);
    instr_ex    = ins;
    instr_valid = v;
    #1;
    $display("txn instr=%08h valid=%0b aluop=%b alusrc=%0b illegal=%0b stall=%0b",
             ins, v, aluop_ex, alusrc_ex, illegal_ex, stall_fetch);
  endtask

  // Advance past the next rising edge so WB outputs can be sampled
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [1:0] sel, input logic we,
                          input logic [4:0] rd, input logic [1:0] gpio);
    check_val({tag, "_regsel"}, 32'(regsel_wb), 32'(sel));
    check_val({tag, "_regwrite"}, 32'(regwrite_wb), 32'(we));
    check_val({tag, "_rd"}, 32'(rd_wb), 32'(rd));
    check_val({tag, "_gpio"}, 32'(gpio_we_wb), 32'(gpio));
  endtask

  initial begin
    rst         = 1'b1;
    instr_ex    = 32'h0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_wb("reset", 2'b10, 1'b0, 5'd0, 2'b00);
    check_val("reset_stall", 32'(stall_fetch), 32'd0);
    rst = 1'b0;

    // add x3,x1,x2
    drive(32'h002081B3, 1'b1);
    check_val("add_aluop", 32'(aluop_ex), 32'h3);
    check_val("add_alusrc", 32'(alusrc_ex), 32'd0);
    check_val("add_illegal", 32'(illegal_ex), 32'd0);
    tick;
    check_wb("add", 2'b10, 1'b1, 5'd3, 2'b00);

    // Asynchronous reset mid-cycle clears WB before the next edge
    #2 rst = 1'b1;
    #1;
    check_wb("async_rst", 2'b10, 1'b0, 5'd0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;

    // addi x1,x0,5
    drive(32'h00500093, 1'b1);
    check_val("addi_aluop", 32'(aluop_ex), 32'h3);
    check_val("addi_alusrc", 32'(alusrc_ex), 32'd1);
    tick;
    check_wb("addi", 2'b10, 1'b1, 5'd1, 2'b00);

    // sub x3,x1,x2
    drive(32'h402081B3, 1'b1);
    check_val("sub_aluop", 32'(aluop_ex), 32'h4);
    // srai x5,x1,3
    drive(32'h4030D293, 1'b1);
    check_val("srai_aluop", 32'(aluop_ex), 32'hA);
    check_val("srai_alusrc", 32'(alusrc_ex), 32'd1);
    check_val("srai_illegal", 32'(illegal_ex), 32'd0);
    // sltu x7,x1,x2
    drive(32'h0020B3B3, 1'b1);
    check_val("sltu_aluop", 32'(aluop_ex), 32'hD);
    tick;
    check_wb("sltu", 2'b10, 1'b1, 5'd7, 2'b00);

    // add x0,x1,x2: writes to x0 are suppressed
    drive(32'h00208033, 1'b1);
    tick;
    check_val("x0_regwrite", 32'(regwrite_wb), 32'd0);

    // csrrw x0,0xF02,x7 -> GPIO out 0
    drive(32'hF0239073, 1'b1);
    check_val("gpio0_aluop", 32'(aluop_ex), 32'h3);
    check_val("gpio0_illegal", 32'(illegal_ex), 32'd0);
    tick;
    check_val("gpio0_we", 32'(gpio_we_wb), 32'h1);
    check_val("gpio0_regwrite", 32'(regwrite_wb), 32'd0);
    // csrrw x0,0xF03,x7 -> GPIO out 1
    drive(32'hF0339073, 1'b1);
    tick;
    check_val("gpio1_we", 32'(gpio_we_wb), 32'h2);
    // csrrw x6,0xF00,x0 -> switch read
    drive(32'hF0001373, 1'b1);
    tick;
    check_wb("gpio_in", 2'b00, 1'b1, 5'd6, 2'b00);
    // csrrw to 0xF04: outside the GPIO window
    drive(32'hF0439073, 1'b1);
    check_val("badcsr_illegal", 32'(illegal_ex), 32'd1);
    tick;
    check_val("badcsr_gpio", 32'(gpio_we_wb), 32'h0);

    // lui x4,0x12345
    drive(32'h12345237, 1'b1);
    check_val("lui_illegal", 32'(illegal_ex), 32'd0);
    tick;
    check_wb("lui", 2'b01, 1'b1, 5'd4, 2'b00);

    // All-zero word
    drive(32'h00000000, 1'b1);
    check_val("zero_illegal", 32'(illegal_ex), 32'd1);
    tick;
    check_val("zero_regwrite", 32'(regwrite_wb), 32'd0);
    check_val("zero_gpio", 32'(gpio_we_wb), 32'h0);
    // srli with funct7 = 0100001
    drive(32'h4230D293, 1'b1);
    check_val("srli_bad_illegal", 32'(illegal_ex), 32'd1);
    tick;
    check_val("srli_bad_regwrite", 32'(regwrite_wb), 32'd0);
    // Bubble carrying a legal encoding
    drive(32'h002081B3, 1'b0);
    check_val("bubble_illegal", 32'(illegal_ex), 32'd0);
    tick;
    check_val("bubble_regwrite", 32'(regwrite_wb), 32'd0);

`ifdef CU_MEXT_EN
    // mul x5,x1,x2 with MUL_CYCLES = 3
    drive(32'h022082B3, 1'b1);
    check_val("mul_aluop", 32'(aluop_ex), 32'h5);
    check_val("mul_stall_c0", 32'(stall_fetch), 32'd1);
    tick;
    check_val("mul_wb_c0", 32'(regwrite_wb), 32'd0);
    check_val("mul_stall_c1", 32'(stall_fetch), 32'd1);
    tick;
    check_val("mul_wb_c1", 32'(regwrite_wb), 32'd0);
    check_val("mul_stall_c2", 32'(stall_fetch), 32'd0);
    tick;
    check_wb("mul_done", 2'b10, 1'b1, 5'd5, 2'b00);
    // Same mul still held: restarts immediately
    check_val("mul_b2b_stall", 32'(stall_fetch), 32'd1);
    tick;
    // Dropping valid while busy aborts
    drive(32'h022082B3, 1'b0);
    check_val("mul_abort_stall", 32'(stall_fetch), 32'd0);
    tick;
    check_val("mul_abort_wb", 32'(regwrite_wb), 32'd0);
    check_val("mul_abort_idle", 32'(stall_fetch), 32'd0);
    // mulhu x5,x1,x2
    drive(32'h0220B2B3, 1'b1);
    check_val("mulhu_aluop", 32'(aluop_ex), 32'h7);
    tick;
    // Reset mid-multiply releases the stall at once
    #2 rst = 1'b1;
    #1;
    check_val("mul_rst_stall", 32'(stall_fetch), 32'd0);
    check_val("mul_rst_wb", 32'(regwrite_wb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
`else
    // Without the M extension the multiply encoding is illegal
    drive(32'h022082B3, 1'b1);
    check_val("mul_illegal", 32'(illegal_ex), 32'd1);
    check_val("mul_nostall", 32'(stall_fetch), 32'd0);
    tick;
    check_val("mul_regwrite", 32'(regwrite_wb), 32'd0);
    check_val("mul_nostall_next", 32'(stall_fetch), 32'd0);
`endif

    drive(32'h0, 1'b0);
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Decode/control unit for the two-stage (EX/WB) RV32 core; successor to the single-cycle combinational decoder.
- Decodes the full 32-bit instruction internally rather than taking pre-split fields.
- Generalises GPIO CSR writes to NUM_GPIO_OUT output ports.
- Adds a multi-cycle multiply stall FSM, registered WB-stage controls, and illegal-instruction flagging.

Parameters:
- NUM_GPIO_OUT, 2, number of output GPIO CSRs at CSR addresses GPIO_OUT_BASE+i.
- GPIO_OUT_BASE, 12'hF02, CSR address of GPIO output 0.
- GPIO_IN_ADDR, 12'hF00, CSR address of the read-only switch input.
- MUL_CYCLES, 3, EX-stage cycles a mul/mulh/mulhu occupies (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- instr_ex  in  32  instruction in EX stage
- instr_valid  in  1  instr_ex holds a real instruction (0 = bubble)
- aluop_ex  out  4  ALU operation, combinational from instr_ex
- alusrc_ex  out  1  0 = rs2, 1 = immediate
- stall_fetch  out  1  hold PC and instr_ex register this cycle
- illegal_ex  out  1  instr_ex is valid but undecodable
- regsel_wb  out  2  00 = GPIO input CSR, 01 = immU (lui), 10 = ALU result
- regwrite_wb  out  1  register-file write enable in WB
- rd_wb  out  5  destination register in WB
- gpio_we_wb  out  NUM_GPIO_OUT  one-hot GPIO output write enable in WB

Behaviour:
- Reset (asynchronous, immediate):
  - FSM returns to IDLE; multiply counter cleared.
  - stall_fetch = 0.
  - regsel_wb = 2'b10; regwrite_wb, rd_wb and gpio_we_wb = 0.
- Opcodes handled:
  - 0110011: R-type. alusrc = 0.
  - 0010011: I-type ALU. alusrc = 1.
  - 0110111: lui. regsel = 01; aluop don't-care, driven 0011.
  - 1110011 with funct3 = 001: csrrw. aluop = 0011, alusrc = 0.
  - Anything else: illegal.
- aluop encoding:
  - and 0000, or 0001, xor 0010, add 0011, sub 0100.
  - mul 0101, mulh 0110, mulhu 0111.
  - sll 1000, srl 1001, sra 1010, slt 1100, sltu 1101.
  - Immediate forms use the same codes.
  - slli/srli require instr[31:25] = 0000000; srai requires 0100000. shamt is instr[24:20]; other funct7 values are illegal.
- csrrw decode:
  - CSR address = instr[31:20].
  - GPIO_OUT_BASE+i (i < NUM_GPIO_OUT): gpio_we bit i set; regwrite = 0.
  - GPIO_IN_ADDR: regsel = 00; regwrite = 1.
  - Any other CSR address: illegal.
- Illegal handling: illegal_ex = instr_valid & undecodable. Illegal instructions and bubbles enter WB with regwrite = 0 and gpio_we = 0.
- x0 rule: regwrite_wb forced to 0 whenever rd = 0.
- WB register (EX->WB latency 1 cycle): loads decoded {regsel, regwrite, rd, gpio_we} on every rising edge where stall_fetch = 0. While stalled, a bubble is loaded (regwrite = 0, gpio_we = 0).
- Multiply FSM, states IDLE and MUL_BUSY:
  - IDLE -> MUL_BUSY when a valid mul-class op is in EX and MUL_CYCLES > 1. Counter loads 1; stall_fetch = 1 combinationally in that same cycle.
  - MUL_BUSY: stall_fetch = 1 while counter < MUL_CYCLES-1; counter increments each cycle.
  - On the cycle counter == MUL_CYCLES-1: stall_fetch = 0, the WB register captures the multiply, and the FSM returns to IDLE.
  - Net effect: a multiply occupies EX for exactly MUL_CYCLES cycles, and stall_fetch is high for MUL_CYCLES-1 of them.
  - MUL_CYCLES = 1: FSM never leaves IDLE; no stall.
- Back-to-back multiplies: after the IDLE return, the next mul re-enters MUL_BUSY in the following cycle. No merged stall.
- Upstream must hold instr_ex/instr_valid stable while stall_fetch = 1. instr_valid dropping during MUL_BUSY aborts the sequence: return to IDLE, bubble to WB.
- Reset mid-multiply: FSM to IDLE immediately, stall released; the multiply is discarded.

Optional Feature:
- Macro CU_MEXT_EN.
- Defined: mul/mulh/mulhu decode as above, and the multiply FSM is present.
- Undefined: R-type funct7 = 0000001 is illegal; the FSM is removed; stall_fetch is tied 0.

Test Plan:
- Reset: rst = 1 mid-run -> all WB outputs 0, regsel_wb = 10, stall_fetch = 0 asynchronously before the next edge.
- add: instr 0x002081B3 (add x3,x1,x2), valid -> aluop_ex = 0011, alusrc_ex = 0. Next cycle: regwrite_wb = 1, rd_wb = 3, regsel_wb = 10.
- mul with MUL_CYCLES = 3: instr 0x022082B3 (mul x5) -> stall_fetch high for exactly 2 cycles; regwrite_wb = 1, rd_wb = 5 on the edge after the third EX cycle; WB bubbles during the stall.
- GPIO write: 0xF0239073 (csrrw x0,0xF02,x7) -> next cycle gpio_we_wb = 01, regwrite_wb = 0. With 0xF0001373 (csrrw x6,0xF00,x0) -> regsel_wb = 00, regwrite_wb = 1, rd_wb = 6.
- lui: 0x12345237 (lui x4) -> regsel_wb = 01, rd_wb = 4.
- Illegal: 0x00000000 or srli with funct7 = 0100001 -> illegal_ex = 1, next cycle regwrite_wb = 0, gpio_we_wb = 0. With CU_MEXT_EN undefined, 0x022082B3 -> illegal_ex = 1, stall_fetch = 0.
